// File: rtl/adc_scan_pkg.sv
// Shared encodings and helpers for the multi-channel ADC block-averaging path.
package adc_scan_pkg;

  typedef enum logic [1:0] {
    AVG_1  = 2'd0,
    AVG_4  = 2'd1,
    AVG_16 = 2'd2,
    AVG_64 = 2'd3
  } avg_e;

  // Extra accumulator bits so a full 64-sample window never overflows.
  localparam int ACC_EXTRA = 6;

  // Window length N = 4**avg.
  function automatic logic [6:0] win_len(input logic [1:0] avg);
    win_len = 7'd1 << {avg, 1'b0};
  endfunction

endpackage

// File: rtl/adc_chan_acc.sv
// One channel's accumulator, sample counter, held result and rd_ok flag.
import adc_scan_pkg::*;

module adc_chan_acc #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hit,
  input  logic [DATA_W-1:0] data,
  input  avg_e              avg_q,
  output logic [DATA_W-1:0] result,
  output logic              rd_ok,
  output logic              done,
  output logic [DATA_W-1:0] done_data
);

  localparam int ACC_W = DATA_W + ACC_EXTRA;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [5:0]       cnt;
  logic             last;

  assign sum       = acc + ACC_W'(data);
  assign last      = ({1'b0, cnt} == (win_len(avg_q) - 7'd1));
  assign done      = hit && last;
  // Shift by 2*avg; the quotient always fits in DATA_W bits.
  assign done_data = DATA_W'(sum >> {avg_q, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      rd_ok  <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      cnt   <= '0;
      rd_ok <= 1'b0;
    end else if (hit) begin
      if (last) begin
        acc    <= '0;
        cnt    <= '0;
        result <= done_data;
        rd_ok  <= 1'b1;
      end else begin
        acc <= sum;
        cnt <= cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_avg.sv
// Multi-channel ADC block averager: per-channel windows of 1/4/16/64 samples,
// a readable result bank and a one-cycle update strobe per new result.
import adc_scan_pkg::*;

module adc_scan_avg #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [CH_W-1:0]   s_chan,
  input  logic [DATA_W-1:0] s_data,
  input  logic [1:0]        avg,
  input  logic [CH_W-1:0]   rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ok,
  output logic              upd_valid,
  output logic [CH_W-1:0]   upd_chan,
  output logic [DATA_W-1:0] upd_data,
  output logic              err
);

  // Handshake: s_valid is a push-only strobe with no ready; a sample is taken
  // on the edge where s_valid=1 unless the channel is out of range or the
  // window selection changes on that same edge.

  avg_e              avg_q;
  logic              win_change;
  logic              in_range;
  logic              accept;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] ok;
  logic [DATA_W-1:0] res  [NUM_CH];
  logic [DATA_W-1:0] ddat [NUM_CH];
  logic              any_done;
  logic [CH_W-1:0]   sel_chan;
  logic [DATA_W-1:0] sel_data;

  assign win_change = (avg != avg_q);
  assign in_range   = ({1'b0, s_chan} < (CH_W+1)'(NUM_CH));
  assign accept     = s_valid && in_range && !win_change;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit[g] = accept && (s_chan == CH_W'(g));

    adc_chan_acc #(.DATA_W(DATA_W)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .clear     (win_change),
      .hit       (hit[g]),
      .data      (s_data),
      .avg_q     (avg_q),
      .result    (res[g]),
      .rd_ok     (ok[g]),
      .done      (done[g]),
      .done_data (ddat[g])
    );
  end

  // At most one channel completes per cycle since only one sample is taken.
  always_comb begin
    any_done = 1'b0;
    sel_chan = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (done[k]) begin
        any_done = 1'b1;
        sel_chan = CH_W'(k);
        sel_data = ddat[k];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_sel == CH_W'(k)) begin
        rd_data = res[k];
        rd_ok   = ok[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_q     <= AVG_1;
      upd_valid <= 1'b0;
      upd_chan  <= '0;
      upd_data  <= '0;
      err       <= 1'b0;
    end else begin
      avg_q     <= avg_e'(avg);
      upd_valid <= any_done;
      if (any_done) begin
        upd_chan <= sel_chan;
        upd_data <= sel_data;
      end
      if (s_valid && !in_range) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed bench for adc_scan_avg with three channels and hand-computed averages.
module tb_adc_scan_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [1:0]  s_chan = '0;
  logic [11:0] s_data = '0;
  logic [1:0]  avg = 2'd0;
  logic [1:0]  rd_sel = '0;
  logic [11:0] rd_data;
  logic        rd_ok;
  logic        upd_valid;
  logic [1:0]  upd_chan;
  logic [11:0] upd_data;
  logic        err;

  int errors = 0;
  int checks = 0;
  int npulse;
  logic [1:0]  lchan;
  logic [11:0] ldata;

  adc_scan_avg #(.NUM_CH(3), .CH_W(2), .DATA_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_chan    (s_chan),
    .s_data    (s_data),
    .avg       (avg),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rd_ok     (rd_ok),
    .upd_valid (upd_valid),
    .upd_chan  (upd_chan),
    .upd_data  (upd_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of input, then return just after the capturing edge.
  task automatic drive(input logic v, input logic [1:0] ch, input logic [11:0] d);
    @(negedge clk);
    s_valid = v;
    s_chan  = ch;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drive_cnt(input logic [1:0] ch, input logic [11:0] d);
    drive(1'b1, ch, d);
    if (upd_valid) begin
      npulse++;
      lchan = upd_chan;
      ldata = upd_data;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_data", upd_data, 0);
    chk("rst_upd_chan", upd_chan, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_ok", rd_ok, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Window 1: every sample is a result, back-to-back pulses
    drive(1'b1, 2'd1, 12'h123);
    chk("w1_a_valid", upd_valid, 1);
    chk("w1_a_chan", upd_chan, 1);
    chk("w1_a_data", upd_data, 12'h123);
    drive(1'b1, 2'd2, 12'hFFF);
    chk("w1_b_valid", upd_valid, 1);
    chk("w1_b_chan", upd_chan, 2);
    chk("w1_b_data", upd_data, 12'hFFF);
    drive(1'b0, 2'd0, 12'h000);
    chk("w1_idle_valid", upd_valid, 0);
    rd_sel = 2'd2;
    #1;
    chk("w1_rd2_data", rd_data, 12'hFFF);
    chk("w1_rd2_ok", rd_ok, 1);
    rd_sel = 2'd0;
    #1;
    chk("w1_rd0_ok", rd_ok, 0);

    // Window 4 on ch0: 10+11+12+14=47, 47>>2=11
    avg = 2'd1;
    drive(1'b0, 2'd0, 12'h000);
    rd_sel = 2'd2;
    #1;
    chk("w4_change_rd_ok", rd_ok, 0);
    chk("w4_change_keep", rd_data, 12'hFFF);
    drive(1'b1, 2'd0, 12'd10);
    chk("w4_s1_novalid", upd_valid, 0);
    drive(1'b1, 2'd0, 12'd11);
    chk("w4_s2_novalid", upd_valid, 0);
    drive(1'b1, 2'd0, 12'd12);
    chk("w4_s3_novalid", upd_valid, 0);
    drive(1'b1, 2'd0, 12'd14);
    chk("w4_s4_valid", upd_valid, 1);
    chk("w4_s4_chan", upd_chan, 0);
    chk("w4_s4_data", upd_data, 12'd11);
    rd_sel = 2'd0;
    #1;
    chk("w4_rd0_data", rd_data, 12'd11);
    chk("w4_rd0_ok", rd_ok, 1);

    // Window 64: 64 x 0xFFF on ch2 interleaved with ch0 ramp 3*i (sum 6048 -> 94)
    avg = 2'd3;
    drive(1'b0, 2'd0, 12'h000);
    npulse = 0;
    for (int i = 0; i < 64; i++) begin
      drive_cnt(2'd2, 12'hFFF);
      if (i < 10) drive_cnt(2'd0, 12'(3 * i));
    end
    chk("w64_ch2_pulses", npulse, 1);
    chk("w64_ch2_chan", lchan, 2);
    chk("w64_ch2_data", ldata, 12'hFFF);
    npulse = 0;
    for (int i = 10; i < 64; i++) drive_cnt(2'd0, 12'(3 * i));
    chk("w64_ch0_pulses", npulse, 1);
    chk("w64_ch0_chan", lchan, 0);
    chk("w64_ch0_data", ldata, 12'h05E);

    // Switch 4 -> 16 with a sample in the switch cycle; 100..115 sum 1720 -> 107
    avg = 2'd1;
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b1, 2'd0, 12'd7);
    drive(1'b1, 2'd0, 12'd9);
    avg = 2'd2;
    drive(1'b1, 2'd0, 12'hFFF);
    chk("sw_drop_valid", upd_valid, 0);
    rd_sel = 2'd0;
    #1;
    chk("sw_rd_ok", rd_ok, 0);
    chk("sw_rd_keep", rd_data, 12'h05E);
    npulse = 0;
    for (int i = 0; i < 15; i++) drive_cnt(2'd0, 12'(100 + i));
    chk("w16_early_pulses", npulse, 0);
    drive(1'b1, 2'd0, 12'd115);
    chk("w16_valid", upd_valid, 1);
    chk("w16_chan", upd_chan, 0);
    chk("w16_data", upd_data, 12'd107);

    // Out-of-range channel
    drive(1'b1, 2'd3, 12'h055);
    chk("oor_err", err, 1);
    chk("oor_novalid", upd_valid, 0);
    drive(1'b1, 2'd1, 12'd5);
    chk("oor_err_sticky", err, 1);
    rd_sel = 2'd3;
    #1;
    chk("oor_rd_data", rd_data, 0);
    chk("oor_rd_ok", rd_ok, 0);

    // Asynchronous reset after 3 of 4 samples
    avg = 2'd1;
    drive(1'b0, 2'd0, 12'h000);
    drive(1'b1, 2'd1, 12'd40);
    drive(1'b1, 2'd1, 12'd40);
    drive(1'b1, 2'd1, 12'd40);
    rd_sel = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", upd_valid, 0);
    chk("mid_rst_data", upd_data, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rd_ok", rd_ok, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 12'h000);
    npulse = 0;
    drive_cnt(2'd1, 12'd8);
    drive_cnt(2'd1, 12'd8);
    drive_cnt(2'd1, 12'd8);
    chk("post_rst_early", npulse, 0);
    drive(1'b1, 2'd1, 12'd12);
    chk("post_rst_valid", upd_valid, 1);
    chk("post_rst_chan", upd_chan, 1);
    chk("post_rst_data", upd_data, 12'd9);
    drive(1'b0, 2'd0, 12'h000);
    chk("post_rst_pulse_end", upd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
